// File: rtl/defl_port_alloc_pkg.sv
// Shared constants and types for the deflection-router port allocator.
package defl_port_alloc_pkg;

  // Router port count: four network links plus the local port.
  localparam int NUM_PORT = 5;
  // Productive-vector bit that selects the local (ejection) port.
  localparam int PORT_L   = 4;

  // One allocation request: a flit and the ports that move it closer to its destination.
  typedef struct packed {
    logic                vld;
    logic [NUM_PORT-1:0] prod;
  } slot_req_t;

endpackage

// File: rtl/defl_port_alloc_if.sv
// Flit bus between the route-computation stage, the local core and the allocator.
interface defl_port_alloc_if #(
  parameter int FLIT_W = 64,
  parameter int NUM_IN = 4
);
  import defl_port_alloc_pkg::*;

  logic [NUM_IN-1:0]                in_valid;
  logic [NUM_IN-1:0][FLIT_W-1:0]    in_flit;
  logic [NUM_IN-1:0][NUM_PORT-1:0]  in_prod;
  logic                             inj_valid;
  logic [FLIT_W-1:0]                inj_flit;
  logic [NUM_PORT-1:0]              inj_prod;
  logic                             inj_ready;
  logic [NUM_IN-1:0]                out_valid;
  logic [NUM_IN-1:0][FLIT_W-1:0]    out_flit;
  logic [NUM_IN-1:0]                out_defl;
  logic                             ej_valid;
  logic [FLIT_W-1:0]                ej_flit;

  modport master (
    output in_valid, in_flit, in_prod, inj_valid, inj_flit, inj_prod,
    input  inj_ready, out_valid, out_flit, out_defl, ej_valid, ej_flit
  );

  modport slave (
    input  in_valid, in_flit, in_prod, inj_valid, inj_flit, inj_prod,
    output inj_ready, out_valid, out_flit, out_defl, ej_valid, ej_flit
  );

endinterface

// File: rtl/defl_slot_pick.sv
// One link of the allocation chain: places a single flit given what earlier-ranked flits left free.
module defl_slot_pick
  import defl_port_alloc_pkg::*;
#(
  parameter int NUM_IN = 4,
  localparam int PTR_W = $clog2(NUM_IN)
) (
  input  slot_req_t         req,
  input  logic              ej_ok,      // injected flits never eject
  input  logic [NUM_IN-1:0] free_in,
  input  logic              ej_free_in,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NUM_IN-1:0] grant,
  output logic              grant_ej,
  output logic              defl,
  output logic [NUM_IN-1:0] free_out,
  output logic              ej_free_out
);

  logic [NUM_IN-1:0] hit;
  logic [PTR_W-1:0]  idx;
  logic              found;

  // Eject first, else lowest free productive link, else first free link from ptr (deflection).
  always_comb begin
    grant    = '0;
    grant_ej = 1'b0;
    defl     = 1'b0;
    found    = 1'b0;
    idx      = '0;
    hit      = req.prod[NUM_IN-1:0] & free_in;
    if (req.vld) begin
      if (ej_ok && req.prod[PORT_L] && ej_free_in) begin
        grant_ej = 1'b1;
      end else if (|hit) begin
        for (int j = 0; j < NUM_IN; j++) begin
          if (hit[j] && !found) begin
            grant[j] = 1'b1;
            found    = 1'b1;
          end
        end
      end else begin
        for (int i = 0; i < NUM_IN; i++) begin
          idx = ptr + PTR_W'(i);
          if (free_in[idx] && !found) begin
            grant[idx] = 1'b1;
            defl       = 1'b1;
            found      = 1'b1;
          end
        end
      end
    end
    free_out    = free_in & ~grant;
    ej_free_out = ej_free_in & ~grant_ej;
  end

endmodule

// File: rtl/defl_port_alloc.sv
// Output-port allocation stage of the bufferless deflection router (1-cycle registered).
module defl_port_alloc
  import defl_port_alloc_pkg::*;
#(
  parameter int FLIT_W = 64,
  parameter int NUM_IN = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  defl_port_alloc_if.slave  bus,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  defl_cnt
);

  localparam int PTR_W = $clog2(NUM_IN);

  // Slot k < NUM_IN serves input (ptr+k) mod NUM_IN; slot NUM_IN is the injection port (ranked last).
  slot_req_t [NUM_IN:0]               s_req;
  logic      [NUM_IN:0][FLIT_W-1:0]   s_flit;
  logic      [NUM_IN:0][NUM_IN-1:0]   s_grant;
  logic      [NUM_IN:0]               s_gej;
  logic      [NUM_IN:0]               s_defl;
  logic      [NUM_IN+1:0][NUM_IN-1:0] free_c;
  logic      [NUM_IN+1:0]             ejf_c;

  logic [PTR_W-1:0]              ptr_q, ptr_d;
  logic [NUM_IN-1:0]             out_valid_q, out_valid_d;
  logic [NUM_IN-1:0]             out_defl_q, out_defl_d;
  logic [NUM_IN-1:0][FLIT_W-1:0] out_flit_q, out_flit_d;
  logic                          ej_valid_q, ej_valid_d;
  logic [FLIT_W-1:0]             ej_flit_q, ej_flit_d;
  logic [CNT_W-1:0]              defl_cnt_q, defl_cnt_d;
  logic [PTR_W:0]                defl_pop;
  logic [CNT_W:0]                cnt_sum;

  assign free_c[0] = '1;
  assign ejf_c[0]  = 1'b1;

  for (genvar k = 0; k < NUM_IN; k++) begin : g_rank
    logic [PTR_W-1:0] src;
    assign src         = ptr_q + PTR_W'(k);
    assign s_req[k]    = '{vld: bus.in_valid[src], prod: bus.in_prod[src]};
    assign s_flit[k]   = bus.in_flit[src];
  end

  // Nothing is accepted from the core while the router is held in reset.
  assign s_req[NUM_IN]  = '{vld: bus.inj_valid & rst_n, prod: bus.inj_prod};
  assign s_flit[NUM_IN] = bus.inj_flit;

  for (genvar k = 0; k <= NUM_IN; k++) begin : g_pick
    defl_slot_pick #(.NUM_IN(NUM_IN)) u_pick (
      .req        (s_req[k]),
      .ej_ok      (k < NUM_IN),
      .free_in    (free_c[k]),
      .ej_free_in (ejf_c[k]),
      .ptr        (ptr_q),
      .grant      (s_grant[k]),
      .grant_ej   (s_gej[k]),
      .defl       (s_defl[k]),
      .free_out   (free_c[k+1]),
      .ej_free_out(ejf_c[k+1])
    );
  end

  // The injected flit is accepted exactly when it found a link.
  assign bus.inj_ready = |s_grant[NUM_IN];

  // Steer granted flits onto their links; unused links keep their old payload.
  always_comb begin
    out_flit_d = out_flit_q;
    out_defl_d = '0;
    ej_flit_d  = ej_flit_q;
    for (int k = 0; k <= NUM_IN; k++) begin
      for (int j = 0; j < NUM_IN; j++) begin
        if (s_grant[k][j]) begin
          out_flit_d[j] = s_flit[k];
          out_defl_d[j] = s_defl[k];
        end
      end
      if (s_gej[k]) ej_flit_d = s_flit[k];
    end
    out_valid_d = ~free_c[NUM_IN+1];
    ej_valid_d  = ~ejf_c[NUM_IN+1];
    ptr_d       = ptr_q + PTR_W'(|bus.in_valid);
  end

  // Saturating deflection counter; clear wins over this cycle's increment.
  always_comb begin
    defl_pop = '0;
    for (int j = 0; j < NUM_IN; j++) defl_pop = defl_pop + (PTR_W+1)'(out_defl_d[j]);
    cnt_sum = {1'b0, defl_cnt_q} + (CNT_W+1)'(defl_pop);
    if (cnt_clr)             defl_cnt_d = '0;
    else if (cnt_sum[CNT_W]) defl_cnt_d = '1;
    else                     defl_cnt_d = cnt_sum[CNT_W-1:0];
  end

  // Stage registers; in-flight flits are dropped on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      out_valid_q <= '0;
      out_defl_q  <= '0;
      out_flit_q  <= '0;
      ej_valid_q  <= 1'b0;
      ej_flit_q   <= '0;
      defl_cnt_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_defl_q  <= out_defl_d;
      out_flit_q  <= out_flit_d;
      ej_valid_q  <= ej_valid_d;
      ej_flit_q   <= ej_flit_d;
      defl_cnt_q  <= defl_cnt_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_defl  = out_defl_q;
  assign bus.out_flit  = out_flit_q;
  assign bus.ej_valid  = ej_valid_q;
  assign bus.ej_flit   = ej_flit_q;
  assign defl_cnt      = defl_cnt_q;

endmodule

// File: tb/tb_defl_port_alloc.sv
// Bench for defl_port_alloc: hand-derived vector table with a scoreboard, plus reset/saturation sequences.
module tb_defl_port_alloc;
  localparam int FW = 64;
  localparam int NI = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cnt_clr;
  logic [CW-1:0] defl_cnt;

  defl_port_alloc_if #(.FLIT_W(FW), .NUM_IN(NI)) bus ();

  defl_port_alloc #(.FLIT_W(FW), .NUM_IN(NI), .CNT_W(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .cnt_clr (cnt_clr),
    .defl_cnt(defl_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]      vld;
    logic [3:0][4:0] prod;
    logic            iv;
    logic [4:0]      ip;
    logic            rdy;
    logic [3:0]      ov;
    logic [3:0]      od;
    logic            ej;
    logic [3:0][2:0] src;   // source index per valid link (4 = injection)
    logic [2:0]      ejsrc;
  } vec_t;

  typedef struct packed {
    logic [3:0]       ov;
    logic [3:0]       od;
    logic             ej;
    logic [3:0][63:0] fl;
    logic [63:0]      ejf;
    logic [15:0]      cnt;
  } exp_t;

  vec_t vt [9];
  exp_t sb [$];
  int   ntests = 0;
  int   nfail  = 0;
  int   exp_cnt = 0;

  function automatic vec_t mk(input logic [3:0] vld, input logic [4:0] p3, p2, p1, p0,
                              input logic iv, input logic [4:0] ip, input logic rdy,
                              input logic [3:0] ov, od, input logic ej,
                              input logic [2:0] s3, s2, s1, s0, ejs);
    vec_t v;
    v.vld = vld; v.prod = {p3, p2, p1, p0}; v.iv = iv; v.ip = ip; v.rdy = rdy;
    v.ov = ov; v.od = od; v.ej = ej; v.src = {s3, s2, s1, s0}; v.ejsrc = ejs;
    return v;
  endfunction

  function automatic logic [63:0] fl(input int id, input int i);
    return 64'hF00D_0000_0000_0000 | (64'(id) << 8) | 64'(i);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.in_valid = '0; bus.in_prod = '0; bus.in_flit = '0;
    bus.inj_valid = 1'b0; bus.inj_prod = '0; bus.inj_flit = '0;
  endtask

  task automatic apply(input vec_t v, input int id);
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < NI; i++) bus.in_flit[i] = fl(id, i);
    bus.in_valid = v.vld; bus.in_prod = v.prod;
    bus.inj_valid = v.iv; bus.inj_prod = v.ip; bus.inj_flit = fl(id, 4);
    #1 chk($sformatf("v%0d inj_ready", id), 64'(bus.inj_ready), 64'(v.rdy));
    exp_cnt += $countones(v.od);
    e.ov = v.ov; e.od = v.od; e.ej = v.ej; e.cnt = 16'(exp_cnt);
    for (int j = 0; j < NI; j++) e.fl[j] = fl(id, int'(v.src[j]));
    e.ejf = fl(id, int'(v.ejsrc));
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk($sformatf("v%0d out_valid", id), 64'(bus.out_valid), 64'(e.ov));
    chk($sformatf("v%0d out_defl", id), 64'(bus.out_defl), 64'(e.od));
    chk($sformatf("v%0d ej_valid", id), 64'(bus.ej_valid), 64'(e.ej));
    chk($sformatf("v%0d defl_cnt", id), 64'(defl_cnt), 64'(e.cnt));
    for (int j = 0; j < NI; j++)
      if (e.ov[j]) chk($sformatf("v%0d out_flit[%0d]", id, j), bus.out_flit[j], e.fl[j]);
    if (e.ej) chk($sformatf("v%0d ej_flit", id), bus.ej_flit, e.ejf);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // vld, p3..p0, iv, ip, rdy, ov, od, ej, src3..src0, ejsrc   (comment: ptr before vector)
    vt[0] = mk(4'b0011, 5'b0, 5'b0, 5'b00010, 5'b00010, 0, 5'b0, 0, 4'b0011, 4'b0001, 0, 0, 0, 0, 1, 0);            // ptr0
    vt[1] = mk(4'b1001, 5'b00100, 5'b0, 5'b0, 5'b00010, 0, 5'b0, 0, 4'b0110, 4'b0000, 0, 0, 3, 0, 0, 0);            // ptr1
    vt[2] = mk(4'b1100, 5'b10000, 5'b10000, 5'b0, 5'b0, 0, 5'b0, 0, 4'b0100, 4'b0100, 1, 0, 3, 0, 0, 2);            // ptr2
    vt[3] = mk(4'b1111, 5'b00001, 5'b01000, 5'b00100, 5'b00100, 1, 5'b00001, 0, 4'b1111, 4'b1010, 0, 1, 0, 2, 3, 0); // ptr3
    vt[4] = mk(4'b0111, 5'b11111, 5'b00000, 5'b00010, 5'b00010, 1, 5'b00010, 1, 4'b1111, 4'b1101, 0, 4, 2, 0, 1, 0); // ptr0
    vt[5] = mk(4'b0000, 5'b11111, 5'b11111, 5'b11111, 5'b11111, 1, 5'b10100, 1, 4'b0100, 4'b0000, 0, 0, 4, 0, 0, 0); // ptr1
    vt[6] = mk(4'b0110, 5'b0, 5'b10010, 5'b10000, 5'b0, 1, 5'b00010, 1, 4'b0110, 4'b0100, 1, 0, 4, 2, 0, 1);         // ptr1
    vt[7] = mk(4'b0000, 5'b0, 5'b0, 5'b0, 5'b0, 0, 5'b0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);                     // ptr2
    vt[8] = mk(4'b1001, 5'b00011, 5'b0, 5'b0, 5'b01111, 0, 5'b0, 0, 4'b0011, 4'b0000, 0, 0, 0, 0, 3, 0);             // ptr2

    // Reset held with full traffic offered
    rst_n = 1'b0; cnt_clr = 1'b0;
    bus.in_valid = 4'b1111; bus.in_prod = {4{5'b00001}}; bus.in_flit = '1;
    bus.inj_valid = 1'b1; bus.inj_prod = 5'b00010; bus.inj_flit = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst out_defl", 64'(bus.out_defl), 64'(0));
    chk("rst ej_valid", 64'(bus.ej_valid), 64'(0));
    chk("rst inj_ready", 64'(bus.inj_ready), 64'(0));
    chk("rst defl_cnt", 64'(defl_cnt), 64'(0));
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) apply(vt[i], i);
    apply(vt[3], 20);   // ptr is 3 again
    apply(vt[4], 21);   // ptr 0 -> 1

    // Asynchronous reset in the middle of a full-load burst
    @(negedge clk);
    bus.in_valid = 4'b1111; bus.in_prod = {4{5'b00001}}; bus.inj_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst out_valid", 64'(bus.out_valid), 64'(0));
    chk("mid rst ej_valid", 64'(bus.ej_valid), 64'(0));
    chk("mid rst defl_cnt", 64'(defl_cnt), 64'(0));
    chk("mid rst inj_ready", 64'(bus.inj_ready), 64'(0));
    @(posedge clk); #1;
    chk("mid rst hold out_valid", 64'(bus.out_valid), 64'(0));
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    exp_cnt = 0;
    apply(vt[0], 30);   // only matches if prio_ptr went back to 0

    // Counter clear beats a deflecting cycle, then drive to saturation
    @(negedge clk);
    bus.in_valid = 4'b1111; bus.in_prod = {4{5'b00001}};
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    chk("clr with defl", 64'(defl_cnt), 64'(0));
    @(negedge clk);
    cnt_clr = 1'b0;
    repeat (21844) @(posedge clk);
    #1 chk("cnt 3 per cycle", 64'(defl_cnt), 64'(65532));
    @(posedge clk); #1;
    chk("cnt reaches max", 64'(defl_cnt), 64'(16'hFFFF));
    @(posedge clk); #1;
    chk("cnt saturates", 64'(defl_cnt), 64'(16'hFFFF));
    @(negedge clk);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    chk("clr at saturation", 64'(defl_cnt), 64'(0));
    @(negedge clk);
    cnt_clr = 1'b0;
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
